// File: rtl/tri_err_pkg.sv
// ============================================================================
//  Module      : tri_err_pkg
//  Description : Shared definitions for the direct error-report receive path:
//                clear-handshake state encodings and error-counter sizing.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tri_err_pkg;

  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ERR_CLR_IDLE = 2'b00,
    ERR_CLR_CLR  = 2'b01,
    ERR_CLR_ACK  = 2'b10
  } err_clr_state_t;

endpackage

`default_nettype wire

// File: rtl/tri_err_sat_cnt.sv
// ============================================================================
//  Module      : tri_err_sat_cnt
//  Description : ERR_CNT_W-bit saturating event counter. A clear restarts the
//                count, and an increment arriving in the clear cycle is kept
//                so that no event is lost across a clear.
//  Ports       : clk   - clock, rising edge
//                rst_n - asynchronous active-low reset
//                inc   - count one event this cycle
//                clr   - restart the count this cycle
//                cnt   - current count, sticks at ERR_CNT_MAX
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tri_err_sat_cnt
  import tri_err_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 clr,
  output logic [ERR_CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? ERR_CNT_W'(1) : '0;
    end else if (inc && (cnt != ERR_CNT_MAX)) begin
      cnt <= cnt + ERR_CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/tri_direct_err_rcv.sv
// ============================================================================
//  Module      : tri_direct_err_rcv
//  Description : Receive side of the direct error-report path. Registers WIDTH
//                error levels, latches unmasked errors as sticky status,
//                records which bit(s) fired first since the last clear and
//                exposes a four-phase req/ack clear handshake.
//                Optional build macro TRI_DIRECT_ERR_RCV_CNT_EN adds the
//                rising-edge detector and a saturating error-event counter;
//                without it err_cnt is tied to zero.
//  Ports       : nclk       - clock, rising edge
//                rst_n      - asynchronous active-low reset
//                vd, gd     - power/ground pins, no logical function
//                err_in     - raw error levels, bit 0 is the MSB
//                err_mask   - 1 ignores the bit (quasi-static)
//                clr_req    - clear request level
//                clr_ack    - clear acknowledge level
//                err_sticky - latched unmasked errors
//                first_err  - bit(s) that set the first sticky error
//                any_err    - OR of err_sticky
//                err_cnt    - saturating count of error events
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tri_direct_err_rcv
  import tri_err_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             nclk,
  input  logic             rst_n,
  inout  wire              vd,
  inout  wire              gd,
  input  logic [0:WIDTH-1] err_in,
  input  logic [0:WIDTH-1] err_mask,
  input  logic             clr_req,
  output logic             clr_ack,
  output logic [0:WIDTH-1] err_sticky,
  output logic [0:WIDTH-1] first_err,
  output logic             any_err,
  output logic [0:7]       err_cnt
);

  // analysis_not_referenced: supply pins carry no logic
  wire unused_analysis_not_referenced = vd | gd;

  logic [0:WIDTH-1] r_err_q;
  logic [0:WIDTH-1] w_hit;
  logic             w_clr;
  err_clr_state_t   r_state;
  err_clr_state_t   w_state_nxt;

  // --------------------------------------------------------------------------
  // Input stage
  // --------------------------------------------------------------------------
  always_ff @(posedge nclk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_q <= '0;
    end else begin
      r_err_q <= err_in;
    end
  end

  assign w_hit = r_err_q & ~err_mask;

  // --------------------------------------------------------------------------
  // Clear handshake
  // --------------------------------------------------------------------------
  always_ff @(posedge nclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ERR_CLR_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    clr_ack     = 1'b0;
    case (r_state)
      ERR_CLR_IDLE: begin
        if (clr_req) begin
          w_state_nxt = ERR_CLR_CLR;
        end
      end
      ERR_CLR_CLR: begin
        w_clr       = 1'b1;
        w_state_nxt = ERR_CLR_ACK;
      end
      ERR_CLR_ACK: begin
        clr_ack = 1'b1;
        if (!clr_req) begin
          w_state_nxt = ERR_CLR_IDLE;
        end
      end
      default: begin
        w_state_nxt = ERR_CLR_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Sticky status and first-error capture. A hit in the clear cycle survives
  // the clear, and becomes the new first error.
  // --------------------------------------------------------------------------
  always_ff @(posedge nclk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= '0;
      first_err  <= '0;
    end else begin
      err_sticky <= (err_sticky & ~{WIDTH{w_clr}}) | w_hit;
      if (w_clr) begin
        first_err <= w_hit;
      end else if (!(|err_sticky) && (|w_hit)) begin
        first_err <= w_hit;
      end
    end
  end

  assign any_err = |err_sticky;

  // --------------------------------------------------------------------------
  // Optional error-event counter: one count per cycle with any new rising bit
  // --------------------------------------------------------------------------
`ifdef TRI_DIRECT_ERR_RCV_CNT_EN
  logic [0:WIDTH-1]       r_err_q2;
  logic                   w_rise_any;
  logic [ERR_CNT_W-1:0]   w_cnt;

  always_ff @(posedge nclk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_q2 <= '0;
    end else begin
      r_err_q2 <= r_err_q;
    end
  end

  assign w_rise_any = |(r_err_q & ~r_err_q2 & ~err_mask);

  tri_err_sat_cnt u_err_cnt (
    .clk   (nclk),
    .rst_n (rst_n),
    .inc   (w_rise_any),
    .clr   (w_clr),
    .cnt   (w_cnt)
  );

  assign err_cnt = w_cnt;
`else
  assign err_cnt = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tri_direct_err_rcv.sv
// ============================================================================
//  Module      : tb_tri_direct_err_rcv
//  Description : Self-checking bench for tri_direct_err_rcv (WIDTH = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tri_direct_err_rcv;

  localparam int W = 4;
`ifdef TRI_DIRECT_ERR_RCV_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic [0:W-1] err_in;
  logic [0:W-1] err_mask;
  logic         clr_req;
  logic         clr_ack;
  logic [0:W-1] err_sticky;
  logic [0:W-1] first_err;
  logic         any_err;
  logic [0:7]   err_cnt;
  wire          vd = 1'b1;
  wire          gd = 1'b0;

  tri_direct_err_rcv #(.WIDTH(W)) dut (
    .nclk       (clk),
    .rst_n      (rst_n),
    .vd         (vd),
    .gd         (gd),
    .err_in     (err_in),
    .err_mask   (err_mask),
    .clr_req    (clr_req),
    .clr_ack    (clr_ack),
    .err_sticky (err_sticky),
    .first_err  (first_err),
    .any_err    (any_err),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [17:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // {sticky, first, any, cnt, ack}
  function automatic logic [17:0] mk(input logic [3:0] s, input logic [3:0] f,
                                     input logic a, input int c, input logic k);
    logic [7:0] cv;
    cv = CNT_ON ? 8'(c) : 8'h00;
    return {s, f, a, cv, k};
  endfunction

  function automatic logic [17:0] snap();
    return {err_sticky, first_err, any_err, err_cnt, clr_ack};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] v);
    err_in = v;
    tick();
    err_in = '0;
    tick();
  endtask

  task automatic do_clear();
    clr_req = 1'b1;
    tick();
    tick();
    clr_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0; err_in = '0; err_mask = '0; clr_req = 1'b0;
    repeat (3) tick();
    sb.push_back('{"reset_state", mk(4'b0000, 4'b0000, 1'b0, 0, 1'b0)});
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, snap(), e.v); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_latch();
    exp_t e;
    pulse(4'b0100);
    sb.push_back('{"basic_latch", mk(4'b0100, 4'b0100, 1'b1, 1, 1'b0)});
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, snap(), e.v); end
    repeat (3) tick();
    sb.push_back('{"basic_hold", mk(4'b0100, 4'b0100, 1'b1, 1, 1'b0)});
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, snap(), e.v); end
  endtask

  task automatic test_first_vs_later();
    exp_t e;
    do_clear();
    sb.push_back('{"after_clear", mk(4'b0000, 4'b0000, 1'b0, 0, 1'b0)});
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, snap(), e.v); end
    pulse(4'b0001);
    repeat (3) tick();
    pulse(4'b1000);
    sb.push_back('{"first_vs_later", mk(4'b1001, 4'b0001, 1'b1, 2, 1'b0)});
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, snap(), e.v); end
  endtask

  task automatic test_mask();
    exp_t e;
    do_clear();
    err_mask = 4'b0010;
    err_in   = 4'b0011;
    repeat (3) tick();
    err_in = '0;
    tick();
    tick();
    sb.push_back('{"mask_hold", mk(4'b0001, 4'b0001, 1'b1, 1, 1'b0)});
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, snap(), e.v); end
    // masking an already-set bit leaves its sticky status alone
    err_mask = 4'b0001;
    repeat (2) tick();
    sb.push_back('{"mask_keeps_sticky", mk(4'b0001, 4'b0001, 1'b1, 1, 1'b0)});
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, snap(), e.v); end
    err_mask = '0;
  endtask

  task automatic test_clear_race();
    exp_t e;
    do_clear();
    pulse(4'b0001);
    sb.push_back('{"race_pre", mk(4'b0001, 4'b0001, 1'b1, 1, 1'b0)});
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, snap(), e.v); end
    // request and error sampled at the same edge: hit lands in the CLR cycle
    clr_req = 1'b1;
    err_in  = 4'b0100;
    tick();
    err_in = '0;
    tick();
    sb.push_back('{"race_set_wins", mk(4'b0100, 4'b0100, 1'b1, 1, 1'b1)});
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, snap(), e.v); end
    repeat (3) tick();
    sb.push_back('{"ack_held", mk(4'b0100, 4'b0100, 1'b1, 1, 1'b1)});
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, snap(), e.v); end
    clr_req = 1'b0;
    #1;
    checks++;
    if (clr_ack !== 1'b1) begin errors++; $display("FAIL ack_before_edge got %b want 1", clr_ack); end
    tick();
    sb.push_back('{"ack_fall", mk(4'b0100, 4'b0100, 1'b1, 1, 1'b0)});
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, snap(), e.v); end
  endtask

  task automatic test_early_drop();
    exp_t e;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    checks++;
    if (clr_ack !== 1'b0) begin errors++; $display("FAIL early_in_clr got %b want 0", clr_ack); end
    tick();
    sb.push_back('{"early_drop_ack", mk(4'b0000, 4'b0000, 1'b0, 0, 1'b1)});
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, snap(), e.v); end
    tick();
    checks++;
    if (clr_ack !== 1'b0) begin errors++; $display("FAIL early_drop_idle got %b want 0", clr_ack); end
  endtask

  task automatic test_saturation();
    exp_t e;
    do_clear();
    for (int i = 0; i < 254; i++) pulse(4'b1000);
    sb.push_back('{"cnt_254", mk(4'b1000, 4'b1000, 1'b1, 254, 1'b0)});
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, snap(), e.v); end
    pulse(4'b1000);
    sb.push_back('{"cnt_255", mk(4'b1000, 4'b1000, 1'b1, 255, 1'b0)});
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, snap(), e.v); end
    for (int i = 255; i < 300; i++) pulse(4'b1000);
    sb.push_back('{"cnt_saturated", mk(4'b1000, 4'b1000, 1'b1, 255, 1'b0)});
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, snap(), e.v); end
    do_clear();
    sb.push_back('{"sat_cleared", mk(4'b0000, 4'b0000, 1'b0, 0, 1'b0)});
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, snap(), e.v); end
  endtask

  task automatic test_reset_mid_clear();
    exp_t e;
    clr_req = 1'b1;
    tick();
    tick();
    pulse(4'b0010);
    sb.push_back('{"accum_in_ack", mk(4'b0010, 4'b0010, 1'b1, 1, 1'b1)});
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, snap(), e.v); end
    #2 rst_n = 1'b0;
    #1;
    sb.push_back('{"async_reset", mk(4'b0000, 4'b0000, 1'b0, 0, 1'b0)});
    e = sb.pop_front(); checks++;
    if (snap() !== e.v) begin errors++; $display("FAIL %s got %h want %h", e.name, snap(), e.v); end
    clr_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    // a fresh request must walk IDLE -> CLR -> ACK
    clr_req = 1'b1;
    tick();
    checks++;
    if (clr_ack !== 1'b0) begin errors++; $display("FAIL post_reset_clr got %b want 0", clr_ack); end
    tick();
    checks++;
    if (clr_ack !== 1'b1) begin errors++; $display("FAIL post_reset_ack got %b want 1", clr_ack); end
    clr_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_latch();
    test_first_vs_later();
    test_mask();
    test_clear_race();
    test_early_drop();
    test_saturation();
    test_reset_mid_clear();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tri_direct_err_rcv.md
# tri_direct_err_rcv

Receiving end of the direct error-report path: collects WIDTH single-bit error levels driven by `tri_direct_err_rpt` instances across a unit and turns them into sticky, maskable status for pervasive logic. Registers the inputs, latches unmasked errors as sticky bits, and captures which bits fired first. Optionally keeps a saturating error-event counter. Software clears status through a four-phase req/ack handshake; no error is lost across a clear.

## Interface
- `WIDTH`, 1: number of direct error bits collected.
- `nclk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `vd` inout 1: power pin, unused logically.
- `gd` inout 1: ground pin, unused logically.
- `err_in` in [0:WIDTH-1]: raw error levels; bit 0 is MSB, big-endian ordering.
- `err_mask` in [0:WIDTH-1]: 1 = ignore that bit; quasi-static.
- `clr_req` in 1: clear request level.
- `clr_ack` out 1: clear acknowledge level.
- `err_sticky` out [0:WIDTH-1]: latched unmasked errors.
- `first_err` out [0:WIDTH-1]: bit(s) that set the first sticky error since the last clear.
- `any_err` out 1: OR of `err_sticky`.
- `err_cnt` out [0:7]: saturating count of error events.

## Operation
- Input stage: `err_q <= err_in`; `err_q2 <= err_q` for edge detection.
- `hit = err_q & ~err_mask`; `rise = err_q & ~err_q2 & ~err_mask`.
- Sticky: `err_sticky <= (err_sticky & ~clr) | hit`. Set wins over clear in the same cycle.
- First-error: load `first_err <= hit` when `err_sticky` is all zero (or being cleared this cycle) and `hit != 0`. Otherwise hold. Simultaneous bits are all captured.
- `any_err = |err_sticky`, combinational from the register.
- Counter: +1 per cycle where `|rise`, independent of how many bits rise. Saturates at 255. Clear resets it to 0, or to 1 if `|rise` in the clear cycle.
- Clear FSM:
  - IDLE: `clr_ack` = 0. On `clr_req` = 1, go to CLR.
  - CLR: one cycle; asserts internal `clr`. Go to ACK.
  - ACK: `clr_ack` = 1. Errors accumulate normally. On `clr_req` = 0, go to IDLE.
  - An encoding that is not a legal state goes to IDLE.
- Masking a bit does not clear its existing sticky bit.
- `vd` and `gd` are ORed into an unused wire marked `analysis_not_referenced`.

## Timing
- Reset values: `err_q`, `err_q2`, `err_sticky`, `first_err`, `err_cnt` = 0; `any_err` = 0; `clr_ack` = 0; state = IDLE.
- Latency: `err_in` high before edge N is seen in `err_q` after N. `err_sticky`, `any_err` and `first_err` update after edge N+1. `err_cnt` also increments after N+1.
- Clear: `clr_req` sampled high at edge N gives CLR during cycle N..N+1. Sticky, first and count are cleared after edge N+1, and `clr_ack` rises then. `clr_ack` falls one edge after `clr_req` is sampled low.
- If `clr_req` drops before `clr_ack` rises, the FSM still completes CLR→ACK, then returns to IDLE on the next edge.
- `rst_n` asserted mid-handshake forces IDLE immediately and drops `clr_ack` asynchronously.
- The requester must not reassert `clr_req` until `clr_ack` = 0.

## Configuration
- `TRI_DIRECT_ERR_RCV_CNT_EN` defined: the `rise`/`err_q2` path and the 8-bit saturating `err_cnt` are built as described.
- `TRI_DIRECT_ERR_RCV_CNT_EN` undefined: no `err_q2` and no counter. `err_cnt` is tied to 8'h00. All other behaviour is unchanged.

## Structure
- Shared package `tri_err_pkg` holds:
  - state encodings `ERR_CLR_IDLE` = 2'b00, `ERR_CLR_CLR` = 2'b01, `ERR_CLR_ACK` = 2'b10;
  - `ERR_CNT_W` = 8;
  - `ERR_CNT_MAX` = 8'hFF.
- One sub-module, `tri_err_sat_cnt`: an ERR_CNT_W-bit saturating counter with inc/clr inputs, instantiated only under the macro.
- Everything else is flat in `tri_direct_err_rcv`.

## Test plan
- Basic latch: WIDTH=4, mask=0, pulse `err_in`=4'b0100 for one cycle. Expect `err_sticky`=4'b0100, `first_err`=4'b0100 and `any_err`=1 two edges later, held after the pulse ends. `err_cnt`=1.
- First vs later: pulse 4'b0001, then 4'b1000 five cycles later. Expect `err_sticky`=4'b1001, `first_err` stays 4'b0001, `err_cnt`=2.
- Mask: mask=4'b0010, hold `err_in`=4'b0011 for 3 cycles. Expect sticky=4'b0001, `err_cnt`=1 (one rise, not 3).
- Clear with set race: sticky=4'b0001. Raise `clr_req` so that the CLR cycle coincides with `hit`=4'b0100. Expect sticky=4'b0100, `first_err`=4'b0100, `err_cnt`=1. `clr_ack` stays high until `clr_req` drops, then falls one edge later.
- Saturation (macro on): 300 separate rising pulses on bit 0. Expect `err_cnt`=255. With the macro off, expect `err_cnt`=0 throughout.
- Reset mid-clear: assert `rst_n`=0 while in ACK. Expect `clr_ack`=0 and all status zero immediately. After release, state is IDLE.
